wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage with load extraction, fault detection, PC redirect and retire counting
module wb_stage #(
    parameter int              XLEN     = 32,
    parameter int              REG_AW   = 5,
    parameter int              CNT_W    = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        w_reg,
    input  logic [1:0]                  wb_sel,
    input  logic [XLEN-1:0]             alu_result,
    input  logic [XLEN-1:0]             mem_rdata,
    input  logic [2:0]                  mem_funct3,
    input  logic [$clog2(XLEN/8)-1:0]   mem_off,
    input  logic [REG_AW-1:0]           dst_addr,
    input  logic [XLEN-1:0]             next_pcD,
    input  logic                        branch_taken,
    input  logic [XLEN-1:0]             branch_target,
    output logic [XLEN-1:0]             next_pc,
    output logic                        write_reg,
    output logic [REG_AW-1:0]           dstreg_addr,
    output logic [XLEN-1:0]             dstreg_data,
    output logic                        out_valid,
    output logic                        load_fault,
    output logic [CNT_W-1:0]            retire_count
);

    logic              w_accept;
    logic [XLEN-1:0]   w_shift;
    logic [XLEN-1:0]   w_load;
    logic              w_mis;
    logic              w_fault;
    logic              w_write;
    logic [XLEN-1:0]   w_data;

    logic [XLEN-1:0]   r_pc;
    logic              r_write;
    logic [REG_AW-1:0] r_addr;
    logic [XLEN-1:0]   r_data;
    logic              r_valid;
    logic              r_fault;
    logic [CNT_W-1:0]  r_cnt;

    assign in_ready = !stall;
    assign w_accept = in_valid & !stall & !flush;
    assign w_shift  = mem_rdata >> {mem_off, 3'b000};

    // Extract and extend the addressed load field from the shifted word.
    always_comb begin
        w_load = '0;
        case (mem_funct3)
            3'b000:  w_load = XLEN'($signed(w_shift[7:0]));
            3'b001:  w_load = XLEN'($signed(w_shift[15:0]));
            3'b010:  w_load = XLEN'($signed(w_shift[31:0]));
            3'b100:  w_load = XLEN'(w_shift[7:0]);
            3'b101:  w_load = XLEN'(w_shift[15:0]);
            3'b110:  w_load = XLEN'(w_shift[31:0]);
            3'b011:  w_load = w_shift;
            default: w_load = '0;
        endcase
    end

    // Flag misaligned offsets and load types that do not exist at this XLEN.
    always_comb begin
        w_mis = 1'b0;
        case (mem_funct3)
            3'b001, 3'b101: w_mis = mem_off[0];
            3'b010:         w_mis = |mem_off[1:0];
            3'b110:         w_mis = (XLEN == 32) | (|mem_off[1:0]);
            3'b011:         w_mis = (XLEN == 32) | (|mem_off);
            3'b111:         w_mis = 1'b1;
            default:        w_mis = 1'b0;
        endcase
    end

    assign w_fault = (wb_sel == 2'd1) & w_mis;
    assign w_write = w_accept & w_reg & (|dst_addr) & !w_fault & (wb_sel != 2'd3);
    assign w_data  = (wb_sel == 2'd0) ? alu_result :
                     (wb_sel == 2'd1) ? w_load     :
                     (wb_sel == 2'd2) ? next_pcD   : '0;

    // Retire state: pulses clear on every non-accept, data/addr/PC/counter move only on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= w_accept;
            r_write <= w_write;
            r_fault <= w_accept & w_fault;
            if (w_accept) begin
                r_addr <= dst_addr;
                r_data <= w_data;
                r_pc   <= branch_taken ? branch_target : next_pcD;
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign next_pc      = r_pc;
    assign write_reg    = r_write;
    assign dstreg_addr  = r_addr;
    assign dstreg_data  = r_data;
    assign out_valid    = r_valid;
    assign load_fault   = r_fault;
    assign retire_count = r_cnt;

endmodule
